// File: rtl/instruction_sequencer.sv
// Two-phase fetch/execute sequencer for the TD4 core; decodes the instruction byte and owns the carry flag.
// Optional self-jump halt detection is enabled by defining SEQ_HALT_DETECT_EN.
module instruction_sequencer #(
    parameter int unsigned N = 4
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic [7:0]   ROM_DATA,
    input  logic [N-1:0] PC_Q,
    input  logic         ALU_CARRY,
    output logic         PC_CS,
    output logic [N-1:0] PC_D,
    output logic [3:0]   IMM,
    output logic [1:0]   SEL,
    output logic [3:0]   LOAD,
    output logic         CARRY,
    output logic         HALT,
    output logic         PHASE
);

    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_IN   = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    localparam logic [3:0] LD_A   = 4'b0001;
    localparam logic [3:0] LD_B   = 4'b0010;
    localparam logic [3:0] LD_OUT = 4'b0100;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t         state;
    logic [7:0]     ir;
    logic           carry_q;
    logic           jump_c;
    logic [N-1:0]   target_c;

    assign target_c = N'(ir[3:0]);
    assign CARRY    = carry_q;

    // State, instruction register and carry flag
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state   <= FETCH;
            ir      <= 8'h00;
            carry_q <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    ir    <= ROM_DATA;
                    state <= EXEC;
                end
                EXEC: begin
                    carry_q <= ALU_CARRY;
                    state   <= FETCH;
`ifdef SEQ_HALT_DETECT_EN
                    if (jump_c && (target_c == PC_Q)) begin
                        state <= HALTED;
                    end
`endif
                end
                default: state <= state;
            endcase
        end
    end

    // Output decode; FETCH and HALT make the counter reload its own value
    always_comb begin
        PC_CS  = 1'b0;
        PC_D   = PC_Q;
        SEL    = SEL_A;
        LOAD   = 4'b0000;
        IMM    = ir[3:0];
        PHASE  = (state != FETCH);
        jump_c = 1'b0;
`ifdef SEQ_HALT_DETECT_EN
        HALT   = (state == HALTED);
`else
        HALT   = 1'b0;
`endif
        case (state)
            EXEC: begin
                PC_D = target_c;
                SEL  = SEL_ZERO;
                case (ir[7:4])
                    4'b0000: begin SEL = SEL_A;    LOAD = LD_A;   end
                    4'b0101: begin SEL = SEL_B;    LOAD = LD_B;   end
                    4'b0011: begin SEL = SEL_ZERO; LOAD = LD_A;   end
                    4'b0111: begin SEL = SEL_ZERO; LOAD = LD_B;   end
                    4'b0001: begin SEL = SEL_B;    LOAD = LD_A;   end
                    4'b0100: begin SEL = SEL_A;    LOAD = LD_B;   end
                    4'b0010: begin SEL = SEL_IN;   LOAD = LD_A;   end
                    4'b0110: begin SEL = SEL_IN;   LOAD = LD_B;   end
                    4'b1001: begin SEL = SEL_B;    LOAD = LD_OUT; end
                    4'b1011: begin SEL = SEL_ZERO; LOAD = LD_OUT; end
                    4'b1111: jump_c = 1'b1;
                    4'b1110: jump_c = ~carry_q;
                    default: LOAD = 4'b0000;
                endcase
                PC_CS = ~jump_c;
            end
            HALTED: SEL = SEL_ZERO;
            default: SEL = SEL_A;
        endcase
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench for instruction_sequencer: a behavioural TD4 model predicts each EXEC cycle,
// a monitor compares the DUT outputs against queued predictions.
module tb_instruction_sequencer;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         clr;
    logic [7:0]   rom_data;
    logic [N-1:0] pc;
    logic         alu_carry;
    logic         pc_cs;
    logic [N-1:0] pc_d;
    logic [3:0]   imm;
    logic [1:0]   sel;
    logic [3:0]   load;
    logic         carry;
    logic         halt;
    logic         phase;

    logic [7:0]   rom [16];

    int tests  = 0;
    int failed = 0;
    bit mon_en = 1'b0;
    bit force_en = 1'b0;
    bit force_c  = 1'b0;

    int unsigned m_pc;
    bit          m_carry;

    typedef struct {
        int unsigned pc;
        int unsigned sel;
        int unsigned load;
        int unsigned pc_cs;
        int unsigned imm;
        int unsigned carry;
        bit          jump;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    instruction_sequencer #(.N(N)) dut (
        .CLK(clk), .CLR(clr), .ROM_DATA(rom_data), .PC_Q(pc), .ALU_CARRY(alu_carry),
        .PC_CS(pc_cs), .PC_D(pc_d), .IMM(imm), .SEL(sel), .LOAD(load),
        .CARRY(carry), .HALT(halt), .PHASE(phase)
    );

    // Program counter and ROM of the surrounding core
    always @(posedge clk or posedge clr) begin
        if (clr)         pc <= '0;
        else if (!pc_cs) pc <= pc_d;
        else             pc <= pc + 1'b1;
    end

    assign rom_data = rom[pc];

    function automatic void chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference behaviour of one TD4 instruction at the model PC
    task automatic issue();
        exp_t e;
        int unsigned op;
        bit c;
        op = int'(rom[m_pc] >> 4);
        c  = force_en ? force_c : bit'($urandom_range(0, 1));
        alu_carry = c;
        e.pc = m_pc; e.imm = rom[m_pc] & 8'h0F; e.carry = m_carry;
        e.sel = 3; e.load = 0; e.jump = 1'b0;
        case (op)
            0:  begin e.sel = 0; e.load = 1; end
            5:  begin e.sel = 1; e.load = 2; end
            3:  begin e.sel = 3; e.load = 1; end
            7:  begin e.sel = 3; e.load = 2; end
            1:  begin e.sel = 1; e.load = 1; end
            4:  begin e.sel = 0; e.load = 2; end
            2:  begin e.sel = 2; e.load = 1; end
            6:  begin e.sel = 2; e.load = 2; end
            9:  begin e.sel = 1; e.load = 4; end
            11: begin e.sel = 3; e.load = 4; end
            15: e.jump = 1'b1;
            14: e.jump = !m_carry;
            default: ;
        endcase
        e.pc_cs = e.jump ? 0 : 1;
        sbq.push_back(e);
        m_pc    = e.jump ? e.imm : (m_pc + 1) % 16;
        m_carry = c;
    endtask

    task automatic run(int n);
        repeat (n) begin
            issue();
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic reset_dut();
        mon_en = 1'b0;
        clr = 1'b1;
        alu_carry = 1'b0;
        @(negedge clk);
        chk("rst_phase", int'(phase), 0);
        chk("rst_halt", int'(halt), 0);
        chk("rst_load", int'(load), 0);
        chk("rst_sel", int'(sel), 0);
        chk("rst_imm", int'(imm), 0);
        chk("rst_carry", int'(carry), 0);
        chk("rst_pc_cs", int'(pc_cs), 0);
        chk("rst_pc_d", int'(pc_d), int'(pc));
        @(negedge clk);
        clr = 1'b0;
        m_pc = 0;
        m_carry = 1'b0;
        mon_en = 1'b1;
    endtask

    // Monitor: every EXEC cycle consumes one prediction; FETCH cycles must hold the counter
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && !clr) begin
                if (phase) begin
                    if (sbq.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("ex_pc", int'(pc), int'(e.pc));
                        chk("ex_sel", int'(sel), int'(e.sel));
                        chk("ex_load", int'(load), int'(e.load));
                        chk("ex_pc_cs", int'(pc_cs), int'(e.pc_cs));
                        chk("ex_imm", int'(imm), int'(e.imm));
                        chk("ex_carry", int'(carry), int'(e.carry));
                        chk("ex_halt", int'(halt), 0);
                        if (e.jump) chk("ex_pc_d", int'(pc_d), int'(e.imm));
                    end
                end else begin
                    chk("fe_pc_cs", int'(pc_cs), 0);
                    chk("fe_pc_d", int'(pc_d), int'(pc));
                    chk("fe_load", int'(load), 0);
                end
            end
        end
    end

    initial begin
        clr = 1'b1;
        alu_carry = 1'b0;
        foreach (rom[i]) rom[i] = 8'h00;

        // MOV A,5 from reset
        rom[0] = 8'h35;
        reset_dut();
        chk("first_phase", int'(phase), 0);
        run(1);
        chk("mov_pc_after", int'(pc), 1);

        // ADD A,1 three times
        foreach (rom[i]) rom[i] = 8'h01;
        reset_dut();
        run(3);
        chk("add_pc_after", int'(pc), 3);

        // JMP 9 with a known carry
        foreach (rom[i]) rom[i] = 8'h00;
        rom[2] = 8'hF9;
        force_en = 1'b1; force_c = 1'b1;
        reset_dut();
        run(3);
        chk("jmp_pc", int'(pc), 9);
        chk("jmp_carry", int'(carry), 1);

        // JNC 12: carry set falls through, carry clear jumps
        foreach (rom[i]) rom[i] = 8'h00;
        rom[3] = 8'hEC;
        force_c = 1'b1;
        reset_dut();
        run(4);
        chk("jnc_c1_pc", int'(pc), 4);
        run(1);
        force_c = 1'b0;
        reset_dut();
        run(4);
        chk("jnc_c0_pc", int'(pc), 12);
        run(1);
        force_en = 1'b0;

        // Self-jump at address 6
        foreach (rom[i]) rom[i] = 8'h00;
        rom[6] = 8'hF6;
        reset_dut();
        run(6);
        mon_en = 1'b0;
        alu_carry = 1'b1;
        @(negedge clk);
        chk("self_sel", int'(sel), 3);
        chk("self_pc_cs", int'(pc_cs), 0);
        chk("self_pc_d", int'(pc_d), 6);
        chk("self_phase", int'(phase), 1);
        @(negedge clk);
        alu_carry = 1'b0;
`ifdef SEQ_HALT_DETECT_EN
        chk("halt_set", int'(halt), 1);
        chk("halt_carry", int'(carry), 1);
        repeat (20) begin
            @(negedge clk);
            chk("halt_pc", int'(pc), 6);
            chk("halt_load", int'(load), 0);
            chk("halt_phase", int'(phase), 1);
        end
        chk("halt_carry_frozen", int'(carry), 1);
`else
        repeat (20) begin
            @(negedge clk);
            chk("nohalt_pc", int'(pc), 6);
            chk("nohalt_halt", int'(halt), 0);
        end
`endif
        clr = 1'b1;
        #1;
        chk("clr_pc", int'(pc), 0);
        chk("clr_halt", int'(halt), 0);

        // CLR half way through OUT B
        foreach (rom[i]) rom[i] = 8'h00;
        rom[0] = 8'h93;
        reset_dut();
        mon_en = 1'b0;
        alu_carry = 1'b1;
        @(posedge clk);
        #3;
        chk("mid_load_before", int'(load), 4);
        chk("mid_phase_before", int'(phase), 1);
        clr = 1'b1;
        #1;
        chk("mid_load", int'(load), 0);
        chk("mid_phase", int'(phase), 0);
        chk("mid_pc_cs", int'(pc_cs), 0);
        @(posedge clk);
        #1;
        chk("mid_carry", int'(carry), 0);
        chk("mid_pc", int'(pc), 0);

        // Random programs; self-jumps are steered away so the stream never halts
        for (int p = 0; p < 6; p++) begin
            for (int a = 0; a < 16; a++) begin
                rom[a] = 8'($urandom_range(0, 255));
                if ((rom[a][7:5] == 3'b111) && (int'(rom[a][3:0]) == a))
                    rom[a][3:0] = 4'(a + 1);
            end
            reset_dut();
            run(60);
        end

        mon_en = 1'b0;
        chk("sb_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
